// File: rtl/config_stream_endpoint_pkg.sv
// rtl/config_stream_endpoint_pkg.sv - header layout, error codes and FSM states for the config mailbox endpoint
package config_stream_endpoint_pkg;

    localparam int HDR_ID_MSB   = 31;
    localparam int HDR_ID_LSB   = 28;
    localparam int HDR_LEN_MSB  = 23;
    localparam int HDR_LEN_LSB  = 12;
    localparam int HDR_CODE_MSB = 10;
    localparam int HDR_CODE_LSB = 0;

    localparam logic [10:0] ERR_OK   = 11'd0;
    localparam logic [10:0] ERR_LEN  = 11'd1;
    localparam logic [10:0] ERR_SIZE = 11'd2;

    typedef enum logic [1:0] {IDLE, RECV, DRAIN, RESP} state_t;

    // Assemble a header word; unused fields stay zero.
    function automatic logic [31:0] make_header(input logic [3:0] id, input logic [11:0] len,
                                                input logic [10:0] code);
        logic [31:0] h;
        h = '0;
        h[HDR_ID_MSB:HDR_ID_LSB]     = id;
        h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
        h[HDR_CODE_MSB:HDR_CODE_LSB] = code;
        return h;
    endfunction

endpackage

// File: rtl/cse_packet_ram.sv
// rtl/cse_packet_ram.sv - single-clock simple dual-port payload buffer with pointers and fill count
module cse_packet_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          wr_en,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    output logic [31:0]   rd_data,
    output logic [CW-1:0] count
);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rd_data = mem[rd_ptr];

    // Pointer and count bookkeeping; clear restarts the buffer for a new packet.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/config_stream_endpoint.sv
// rtl/config_stream_endpoint.sv - loopback config mailbox on an Avalon-ST command/response pair; CSE_RESP_CHECKSUM_EN appends an XOR checksum word
module config_stream_endpoint
    import config_stream_endpoint_pkg::*;
#(
    parameter int READY_LATENCY  = 0,
    parameter int HAS_URGENT     = 0,
    parameter int HAS_STATUS     = 0,
    parameter int HAS_STREAM     = 0,
    parameter int MAX_SIZE       = 256,
    parameter int STREAM_WIDTH   = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CLOCK_RATE_CLK = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    command_ready,
    input  logic                    command_valid,
    input  logic [31:0]             command_data,
    input  logic                    command_startofpacket,
    input  logic                    command_endofpacket,
    input  logic                    response_ready,
    output logic                    response_valid,
    output logic [31:0]             response_data,
    output logic                    response_startofpacket,
    output logic                    response_endofpacket,
    output logic                    command_invalid,
    output logic                    urgent_ready,
    input  logic                    urgent_valid,
    input  logic [31:0]             urgent_data,
    output logic                    stream_ready,
    input  logic                    stream_valid,
    input  logic [STREAM_WIDTH-1:0] stream_data,
    output logic                    stream_active
);

`ifdef CSE_RESP_CHECKSUM_EN
    localparam bit CHECKSUM_EN = 1'b1;
`else
    localparam bit CHECKSUM_EN = 1'b0;
`endif

    localparam int CW = $clog2(MAX_SIZE + 1);
    // Payload words allowed once the header has taken its slot.
    localparam logic [CW-1:0] PAYLOAD_CAP = CW'(MAX_SIZE - 1);

    localparam bit BAD_PARAMS = (HAS_URGENT != 0) || (HAS_STATUS != 0) || (HAS_STREAM != 0) ||
                                (READY_LATENCY != 0) || (STREAM_WIDTH != 32) || (DATA_WIDTH != 32) ||
                                (MAX_SIZE < 2) || (MAX_SIZE > 4096);

    // Unsupported parameter combinations: simulation stops with a message; synthesis
    // fails on the deliberately nonexistent module below.
    generate
        if (BAD_PARAMS) begin : g_param_error
`ifdef SYNTHESIS
            instantiated_with_wrong_parameters_error_see_comment_above wrong_parameters ();
`else
            initial begin
                $display("config_stream_endpoint: unsupported parameters (sideband enables, ready latency, widths or MAX_SIZE)");
                $stop;
            end
`endif
        end
    endgenerate

    assign urgent_ready  = 1'b0;
    assign stream_ready  = 1'b0;
    assign stream_active = 1'b0;

    logic unused_sideband;
    assign unused_sideband = ^{urgent_valid, urgent_data, stream_valid, stream_data};

    state_t        state;
    logic [3:0]    hdr_id;
    logic [11:0]   hdr_len;
    logic [10:0]   err;
    logic [31:0]   chk;

    logic          cmd_fire, resp_fire, overflow, new_hdr, pkt_end;
    logic          ram_wr, ram_rd;
    logic [31:0]   ram_rdata;
    logic [CW-1:0] ram_count, end_count;
    logic [3:0]    end_id;
    logic [11:0]   end_len;
    logic [10:0]   end_err;
    logic [31:0]   end_word;
    logic          end_eop;

    cse_packet_ram #(.DEPTH(MAX_SIZE), .CW(CW)) u_ram (
        .clk     (clk),
        .reset   (reset),
        .clear   (new_hdr),
        .wr_en   (ram_wr),
        .wr_data (command_data),
        .rd_en   (ram_rd),
        .rd_data (ram_rdata),
        .count   (ram_count)
    );

    // Handshakes, buffer controls and the response header produced when a packet ends.
    always_comb begin
        cmd_fire  = command_valid && command_ready;
        resp_fire = response_valid && response_ready;
        overflow  = (state == RECV) && (ram_count >= PAYLOAD_CAP);
        new_hdr   = cmd_fire && command_startofpacket && ((state == IDLE) || (state == RECV));
        ram_wr    = cmd_fire && (state == RECV) && !command_startofpacket && !overflow;
        ram_rd    = (state == RESP) && resp_fire && !response_endofpacket && (ram_count != '0);
        pkt_end   = cmd_fire && command_endofpacket &&
                    (((state == IDLE) && command_startofpacket) || (state == RECV) || (state == DRAIN));
        end_id    = new_hdr ? command_data[HDR_ID_MSB:HDR_ID_LSB] : hdr_id;
        end_len   = new_hdr ? command_data[HDR_LEN_MSB:HDR_LEN_LSB] : hdr_len;
        end_count = new_hdr ? '0 : ram_count + CW'(ram_wr);
        end_err   = ERR_OK;
        if (!new_hdr) end_err = overflow ? ERR_SIZE : err;
        if ((end_err == ERR_OK) && (13'(end_count) != {1'b0, end_len})) end_err = ERR_LEN;
        end_word  = (end_err != ERR_OK) ? make_header(end_id, 12'd0, end_err)
                                        : make_header(end_id, 12'(end_count), ERR_OK);
        end_eop   = (end_err != ERR_OK) || ((end_count == '0) && !CHECKSUM_EN);
    end

    // Packet FSM: receive/drain commands, then stream the response with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                  <= IDLE;
            command_ready          <= 1'b0;
            command_invalid        <= 1'b0;
            response_valid         <= 1'b0;
            response_data          <= '0;
            response_startofpacket <= 1'b0;
            response_endofpacket   <= 1'b0;
            hdr_id                 <= '0;
            hdr_len                <= '0;
            err                    <= ERR_OK;
            chk                    <= '0;
        end else begin
            command_invalid <= 1'b0;
            if (new_hdr) begin
                hdr_id  <= command_data[HDR_ID_MSB:HDR_ID_LSB];
                hdr_len <= command_data[HDR_LEN_MSB:HDR_LEN_LSB];
                err     <= ERR_OK;
            end
            case (state)
                IDLE: begin
                    command_ready <= 1'b1;
                    if (cmd_fire && !command_startofpacket) command_invalid <= 1'b1;
                    if (new_hdr) state <= RECV;
                end
                RECV: begin
                    if (cmd_fire && command_startofpacket) begin
                        command_invalid <= 1'b1;
                    end else if (cmd_fire && overflow) begin
                        err   <= ERR_SIZE;
                        state <= DRAIN;
                    end
                end
                DRAIN: ;
                RESP: begin
                    if (resp_fire) begin
                        response_startofpacket <= 1'b0;
                        if (response_endofpacket) begin
                            response_valid       <= 1'b0;
                            response_data        <= '0;
                            response_endofpacket <= 1'b0;
                            command_ready        <= 1'b1;
                            state                <= IDLE;
                        end else if (ram_count != '0) begin
                            response_data        <= ram_rdata;
                            chk                  <= chk ^ ram_rdata;
                            response_endofpacket <= (ram_count == CW'(1)) && !CHECKSUM_EN;
                        end else begin
                            response_data        <= chk;
                            response_endofpacket <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (pkt_end) begin
                state                  <= RESP;
                command_ready          <= 1'b0;
                response_valid         <= 1'b1;
                response_data          <= end_word;
                response_startofpacket <= 1'b1;
                response_endofpacket   <= end_eop;
                chk                    <= end_word;
            end
        end
    end

endmodule

// File: tb/tb_config_stream_endpoint.sv
// tb/tb_config_stream_endpoint.sv - directed self-checking bench for config_stream_endpoint
module tb_config_stream_endpoint;

    logic        clk = 1'b0;
    logic        reset;
    logic        command_ready, command_valid, command_startofpacket, command_endofpacket;
    logic [31:0] command_data;
    logic        response_ready, response_valid, response_startofpacket, response_endofpacket;
    logic [31:0] response_data;
    logic        command_invalid;
    logic        urgent_ready, urgent_valid;
    logic [31:0] urgent_data;
    logic        stream_ready, stream_valid, stream_active;
    logic [31:0] stream_data;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] rq[$];
    logic        rs[$];
    logic        re[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    config_stream_endpoint dut (
        .clk                    (clk),
        .reset                  (reset),
        .command_ready          (command_ready),
        .command_valid          (command_valid),
        .command_data           (command_data),
        .command_startofpacket  (command_startofpacket),
        .command_endofpacket    (command_endofpacket),
        .response_ready         (response_ready),
        .response_valid         (response_valid),
        .response_data          (response_data),
        .response_startofpacket (response_startofpacket),
        .response_endofpacket   (response_endofpacket),
        .command_invalid        (command_invalid),
        .urgent_ready           (urgent_ready),
        .urgent_valid           (urgent_valid),
        .urgent_data            (urgent_data),
        .stream_ready           (stream_ready),
        .stream_valid           (stream_valid),
        .stream_data            (stream_data),
        .stream_active          (stream_active)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Called at a negedge; returns at the negedge after the word transferred.
    task automatic send_word(input logic [31:0] d, input logic s, input logic e);
        int n;
        n = 0;
        command_valid         = 1'b1;
        command_data          = d;
        command_startofpacket = s;
        command_endofpacket   = e;
        while (!command_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_val("cmd_timeout", 32'd0, 32'd1);
        @(negedge clk);
        command_valid         = 1'b0;
        command_startofpacket = 1'b0;
        command_endofpacket   = 1'b0;
    endtask

    // Captures one response packet; optionally stalls 5 cycles at word index stall_idx.
    task automatic collect(input int stall_idx);
        int          cyc;
        logic        done;
        logic [31:0] held;
        cyc  = 0;
        done = 1'b0;
        rq.delete();
        rs.delete();
        re.delete();
        response_ready = 1'b1;
        while (!done && cyc < 2000) begin
            if (response_valid) begin
                if (rq.size() == stall_idx) begin
                    held = response_data;
                    response_ready = 1'b0;
                    repeat (5) begin
                        @(negedge clk);
                        check_val("hold_data", response_data, held);
                        check_val("hold_valid", {31'b0, response_valid}, 32'd1);
                    end
                    response_ready = 1'b1;
                end
                check_val("busy_ready", {31'b0, command_ready}, 32'd0);
                rq.push_back(response_data);
                rs.push_back(response_startofpacket);
                re.push_back(response_endofpacket);
                if (response_endofpacket) done = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        if (!done) check_val("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic seal_success();
`ifdef CSE_RESP_CHECKSUM_EN
        logic [31:0] x;
        x = '0;
        foreach (exp_q[i]) x ^= exp_q[i];
        exp_q.push_back(x);
`endif
    endtask

    task automatic compare_resp(input string tag);
        check_val($sformatf("%s_words", tag), 32'(rq.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rq.size(); i++) begin
            check_val($sformatf("%s_w%0d", tag, i), rq[i], exp_q[i]);
            check_val($sformatf("%s_sop%0d", tag, i), {31'b0, rs[i]}, {31'b0, (i == 0)});
            check_val($sformatf("%s_eop%0d", tag, i), {31'b0, re[i]}, {31'b0, (i == exp_q.size() - 1)});
        end
    endtask

    initial begin
        reset                 = 1'b1;
        command_valid         = 1'b0;
        command_data          = '0;
        command_startofpacket = 1'b0;
        command_endofpacket   = 1'b0;
        response_ready        = 1'b0;
        urgent_valid          = 1'b0;
        urgent_data           = '0;
        stream_valid          = 1'b0;
        stream_data           = '0;
        repeat (3) @(negedge clk);
        check_val("rst_cmd_ready", {31'b0, command_ready}, 32'd0);
        check_val("rst_resp_valid", {31'b0, response_valid}, 32'd0);
        check_val("rst_resp_data", response_data, 32'd0);
        check_val("rst_sop_eop_inv", {29'b0, response_startofpacket, response_endofpacket, command_invalid}, 32'd0);
        check_val("rst_ties", {29'b0, urgent_ready, stream_ready, stream_active}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_val("ready_after_rst", {31'b0, command_ready}, 32'd1);

        // Two-word payload echo
        send_word(32'h3000_2005, 1'b1, 1'b0);
        send_word(32'h0000_000A, 1'b0, 1'b0);
        send_word(32'h0000_000B, 1'b0, 1'b1);
        check_val("t1_latency", {31'b0, response_valid}, 32'd1);
        collect(-1);
        exp_q = '{32'h3000_2000, 32'h0000_000A, 32'h0000_000B};
        seal_success();
        compare_resp("t1");
        check_val("t1_back_idle", {31'b0, command_ready}, 32'd1);

        // Header-only packet
        send_word(32'h1000_0007, 1'b1, 1'b1);
        collect(-1);
        exp_q = '{32'h1000_0000};
        seal_success();
        compare_resp("t2");

        // Length mismatch
        send_word(32'h0000_3001, 1'b1, 1'b0);
        send_word(32'h0000_0055, 1'b0, 1'b1);
        collect(-1);
        exp_q = '{32'h0000_0001};
        compare_resp("t3");

        // Oversize: 300 words against MAX_SIZE 256
        send_word(32'h5000_0000, 1'b1, 1'b0);
        for (int i = 1; i < 300; i++) send_word(32'(i), 1'b0, (i == 299));
        collect(-1);
        exp_q = '{32'h5000_0002};
        compare_resp("t4");

        // Exactly MAX_SIZE words fits
        send_word(32'h800F_F000, 1'b1, 1'b0);
        for (int i = 1; i < 256; i++) send_word(32'(i * 3), 1'b0, (i == 255));
        collect(-1);
        exp_q.delete();
        exp_q.push_back(32'h800F_F000);
        for (int i = 1; i < 256; i++) exp_q.push_back(32'(i * 3));
        seal_success();
        compare_resp("t8");

        // Non-SOP word in IDLE, then a stalled response
        send_word(32'h0000_DEAD, 1'b0, 1'b0);
        check_val("inv_pulse", {31'b0, command_invalid}, 32'd1);
        @(negedge clk);
        check_val("inv_one_cycle", {31'b0, command_invalid}, 32'd0);
        repeat (3) @(negedge clk);
        check_val("inv_no_resp", {31'b0, response_valid}, 32'd0);
        send_word(32'h7000_3009, 1'b1, 1'b0);
        send_word(32'h0000_0001, 1'b0, 1'b0);
        send_word(32'h0000_0002, 1'b0, 1'b0);
        send_word(32'h0000_0003, 1'b0, 1'b1);
        collect(1);
        exp_q = '{32'h7000_3000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
        seal_success();
        compare_resp("t5");

        // SOP mid-packet restarts
        send_word(32'h2000_1001, 1'b1, 1'b0);
        send_word(32'h0000_0011, 1'b0, 1'b0);
        send_word(32'h4000_1003, 1'b1, 1'b0);
        check_val("midsop_inv", {31'b0, command_invalid}, 32'd1);
        send_word(32'h0000_0022, 1'b0, 1'b1);
        collect(-1);
        exp_q = '{32'h4000_1000, 32'h0000_0022};
        seal_success();
        compare_resp("t6");

        // Reset mid-packet abandons the buffer
        send_word(32'h6000_2000, 1'b1, 1'b0);
        send_word(32'h0000_0077, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_val("midrst_ready", {31'b0, command_ready}, 32'd0);
        check_val("midrst_valid", {31'b0, response_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_val("midrst_ready_up", {31'b0, command_ready}, 32'd1);
        send_word(32'h6000_1000, 1'b1, 1'b0);
        send_word(32'h0000_0009, 1'b0, 1'b1);
        collect(-1);
        exp_q = '{32'h6000_1000, 32'h0000_0009};
        seal_success();
        compare_resp("t7");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
